tick_timer_scheduler: RTL

Shared countdown-timer scheduler for the lock controller. One internal prescaler derives a single-cycle tick enable from CLK, and that tick is shared among N independent countdown timers: keypad inactivity, wrong-code lockout and door-open. Clients start, restart or cancel their timer and receive a one-cycle expiry pulse. Everything runs in the CLK domain; no derived clocks are produced.

---
 rtl/tick_timer_scheduler.sv | 91 +++++++++
 1 files changed

// File: rtl/tick_timer_scheduler.sv
// rtl/tick_timer_scheduler.sv - shared-prescaler countdown timers with start/restart/cancel and one-cycle expiry pulses
module tick_timer_scheduler #(
    parameter int DIV_VALUE = 1000,
    parameter int DIV_WIDTH = 10,
    parameter int N_TIMERS  = 3,
    parameter int CNT_WIDTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [N_TIMERS-1:0]           START,
    input  logic [N_TIMERS*CNT_WIDTH-1:0] LOAD_VALUE,
    input  logic [N_TIMERS-1:0]           CANCEL,
    output logic [N_TIMERS-1:0]           BUSY,
    output logic [N_TIMERS-1:0]           EXPIRED,
    output logic                          TICK
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_VALUE - 1);

    state_t               state    [N_TIMERS];
    logic [CNT_WIDTH-1:0] count    [N_TIMERS];
    logic [CNT_WIDTH-1:0] load_val [N_TIMERS];
    logic [DIV_WIDTH-1:0] prescaler;
    logic [N_TIMERS-1:0]  run_nxt;
    logic [N_TIMERS-1:0]  done_nxt;
    logic                 any_busy;

    always_comb begin
        BUSY = '0;
        for (int i = 0; i < N_TIMERS; i++) begin
            BUSY[i] = (state[i] == RUN);
        end
    end

    assign any_busy = |BUSY;
    assign TICK     = any_busy && (prescaler == DIV_LAST);

    // Next-state decode shared by the FSMs and the prescaler, priority CANCEL > START > TICK.
    always_comb begin
        run_nxt  = '0;
        done_nxt = '0;
        for (int i = 0; i < N_TIMERS; i++) begin
            load_val[i] = LOAD_VALUE[i*CNT_WIDTH +: CNT_WIDTH];
            if (CANCEL[i]) begin
                run_nxt[i]  = 1'b0;
                done_nxt[i] = 1'b0;
            end else if (START[i]) begin
                run_nxt[i]  = (load_val[i] != '0);
                done_nxt[i] = (load_val[i] == '0);
            end else if (state[i] == RUN) begin
                if (TICK && count[i] == CNT_WIDTH'(1)) begin
                    done_nxt[i] = 1'b1;
                end else begin
                    run_nxt[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prescaler <= '0;
            EXPIRED   <= '0;
            for (int i = 0; i < N_TIMERS; i++) begin
                state[i] <= IDLE;
                count[i] <= '0;
            end
        end else begin
            // Parked at zero when nothing will be running so a fresh start sees a full first tick.
            if (!any_busy || TICK || run_nxt == '0) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + DIV_WIDTH'(1);
            end
            EXPIRED <= done_nxt;
            for (int i = 0; i < N_TIMERS; i++) begin
                state[i] <= run_nxt[i] ? RUN : IDLE;
                if (CANCEL[i]) begin
                    count[i] <= '0;
                end else if (START[i]) begin
                    count[i] <= load_val[i];
                end else if (state[i] == RUN && TICK) begin
                    count[i] <= count[i] - CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule
